// File: rtl/energy_threshold_estimator.sv
// ---------------------------------------------------------------------------
// energy_threshold_estimator
//
// Front-end for the event-detection FSM. Every accepted signed sample is
// squared and folded into two moving sums of squares:
//   - energy : sum over the last SHORT_SIZE accepted samples
//   - TH     : sum over the last LONG_SIZE samples accepted by the long window
// The long (background) window holds while `freeze` is high, so event energy
// never leaks into the threshold. Freeze is only honoured after the long
// window has filled once (initDone).
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   sample_in    in   signed sample, SAMPLE_W bits
//   sample_valid in   sample_in valid this cycle
//   freeze       in   holds the long-window update when high (after init)
//   energy       out  64-bit signed short-window sum of squares
//   TH           out  64-bit signed long-window sum of squares (optionally floored)
//   initDone     out  long window has filled; sticky until reset
//   out_valid    out  one-cycle pulse, energy/TH updated this cycle
//
// Handshake: sample_valid is a qualifier with no back-pressure; a sample
// presented with sample_valid=1 is always accepted at that clock edge and
// its effect is visible on energy/TH one cycle later, flagged by out_valid.
//
// Optional feature (macro TH_FLOOR_EN): when defined, the TH output is
// max(long_sum, TH_FLOOR). The internal long sum stays unclamped so the
// moving sum is never corrupted by the floor. When undefined, TH is the raw
// long sum.
// ---------------------------------------------------------------------------
module energy_threshold_estimator #(
    parameter int     SAMPLE_W   = 16,
    parameter int     SHORT_SIZE = 15,
    parameter int     LONG_SIZE  = 31,
    parameter longint TH_FLOOR   = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       freeze,
    output logic signed [63:0]         energy,
    output logic signed [63:0]         TH,
    output logic                       initDone,
    output logic                       out_valid
);

    localparam int SQ_W = 2 * SAMPLE_W;
    localparam int SPW  = (SHORT_SIZE > 1) ? $clog2(SHORT_SIZE) : 1;
    localparam int LPW  = (LONG_SIZE > 1) ? $clog2(LONG_SIZE) : 1;
    localparam int FW   = $clog2(LONG_SIZE + 1);

    localparam logic [SPW-1:0] S_LAST      = SPW'(SHORT_SIZE - 1);
    localparam logic [LPW-1:0] L_LAST      = LPW'(LONG_SIZE - 1);
    localparam logic [FW-1:0]  FILL_LAST   = FW'(LONG_SIZE - 1);

    // Elaboration-time sanity checks on the configuration.
    if (LONG_SIZE <= SHORT_SIZE) begin : g_bad_sizes
        $error("LONG_SIZE must be greater than SHORT_SIZE");
    end
    if (TH_FLOOR < 0) begin : g_bad_floor
        $error("TH_FLOOR must be non-negative");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [SQ_W-1:0]    sbuf_q [SHORT_SIZE];
    logic [SQ_W-1:0]    lbuf_q [LONG_SIZE];
    logic [SPW-1:0]     sptr_q, sptr_d;
    logic [LPW-1:0]     lptr_q, lptr_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic signed [63:0] energy_q, energy_d;
    logic signed [63:0] long_sum_q, long_sum_d;
    logic               init_done_q, init_done_d;
    logic               out_valid_q, out_valid_d;

    // -----------------------------------------------------------------------
    // Square. A signed*signed product of two SAMPLE_W values fits in 2*SAMPLE_W
    // bits and is never negative (worst case (-2^(W-1))^2 = 2^(2W-2)), so it is
    // zero-extended into the 64-bit sums.
    // -----------------------------------------------------------------------
    logic signed [SQ_W-1:0] sq_s;
    logic [63:0]            sq_ext;
    logic [63:0]            s_evict_ext;
    logic [63:0]            l_evict_ext;
    logic                   long_en;

    assign sq_s        = sample_in * sample_in;
    assign sq_ext      = {{(64 - SQ_W){1'b0}}, sq_s};
    assign s_evict_ext = {{(64 - SQ_W){1'b0}}, sbuf_q[sptr_q]};
    assign l_evict_ext = {{(64 - SQ_W){1'b0}}, lbuf_q[lptr_q]};

    // Freeze only gates the long window once it has filled.
    assign long_en = sample_valid && (!freeze || !init_done_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        sptr_d      = sptr_q;
        lptr_d      = lptr_q;
        fill_d      = fill_q;
        energy_d    = energy_q;
        long_sum_d  = long_sum_q;
        init_done_d = init_done_q;
        out_valid_d = sample_valid;

        if (sample_valid) begin
            energy_d = energy_q + $signed(sq_ext) - $signed(s_evict_ext);
            sptr_d   = (sptr_q == S_LAST) ? '0 : sptr_q + SPW'(1);
        end

        if (long_en) begin
            long_sum_d = long_sum_q + $signed(sq_ext) - $signed(l_evict_ext);
            lptr_d     = (lptr_q == L_LAST) ? '0 : lptr_q + LPW'(1);
            if (fill_q != FW'(LONG_SIZE)) begin
                fill_d = fill_q + FW'(1);
            end
            // initDone rises together with the sum that holds the
            // LONG_SIZE-th sample.
            if (fill_q == FILL_LAST) begin
                init_done_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            sptr_q      <= '0;
            lptr_q      <= '0;
            fill_q      <= '0;
            energy_q    <= '0;
            long_sum_q  <= '0;
            init_done_q <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < SHORT_SIZE; i++) begin
                sbuf_q[i] <= '0;
            end
            for (int i = 0; i < LONG_SIZE; i++) begin
                lbuf_q[i] <= '0;
            end
        end else begin
            sptr_q      <= sptr_d;
            lptr_q      <= lptr_d;
            fill_q      <= fill_d;
            energy_q    <= energy_d;
            long_sum_q  <= long_sum_d;
            init_done_q <= init_done_d;
            out_valid_q <= out_valid_d;
            if (sample_valid) begin
                sbuf_q[sptr_q] <= sq_s;
            end
            if (long_en) begin
                lbuf_q[lptr_q] <= sq_s;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign energy    = energy_q;
    assign initDone  = init_done_q;
    assign out_valid = out_valid_q;

`ifdef TH_FLOOR_EN
    // Floor applies to the output only; long_sum_q keeps the true sum.
    assign TH = (long_sum_q < TH_FLOOR) ? TH_FLOOR : long_sum_q;
`else
    assign TH = long_sum_q;
`endif

endmodule

// File: tb/tb_energy_threshold_estimator.sv
// ---------------------------------------------------------------------------
// tb_energy_threshold_estimator
//
// Directed scenarios plus randomized traffic. The reference model keeps the
// history of accepted squares in queues and computes each moving sum as the
// plain sum of the most recent window entries.
// ---------------------------------------------------------------------------
module tb_energy_threshold_estimator;

    localparam int     SAMPLE_W   = 16;
    localparam int     SHORT_SIZE = 15;
    localparam int     LONG_SIZE  = 31;
    localparam longint TH_FLOOR   = 64;

    // ---------------- clock / reset block ----------------
    logic                       clock = 1'b0;
    logic                       reset;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid;
    logic                       freeze;
    logic signed [63:0]         energy;
    logic signed [63:0]         TH;
    logic                       initDone;
    logic                       out_valid;

    always #5 clock = ~clock;

    energy_threshold_estimator #(
        .SAMPLE_W  (SAMPLE_W),
        .SHORT_SIZE(SHORT_SIZE),
        .LONG_SIZE (LONG_SIZE),
        .TH_FLOOR  (TH_FLOOR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .freeze      (freeze),
        .energy      (energy),
        .TH          (TH),
        .initDone    (initDone),
        .out_valid   (out_valid)
    );

    // ---------------- reference model ----------------
    longint short_hist[$];
    longint long_hist[$];
    int     long_cnt;
    bit     m_init;
    bit     m_ov;

    int checks_cnt = 0;
    int errors_cnt = 0;

    function automatic logic [63:0] exp_energy();
        longint s = 0;
        foreach (short_hist[i]) s += short_hist[i];
        return s;
    endfunction

    function automatic logic [63:0] exp_th();
        longint s = 0;
        foreach (long_hist[i]) s += long_hist[i];
`ifdef TH_FLOOR_EN
        if (s < TH_FLOOR) s = TH_FLOOR;
`endif
        return s;
    endfunction

    function automatic void model_reset();
        short_hist.delete();
        long_hist.delete();
        long_cnt = 0;
        m_init   = 1'b0;
        m_ov     = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input logic signed [SAMPLE_W-1:0] s,
                                       input bit f);
        longint x;
        longint sq;
        m_ov = v;
        if (!v) return;
        x  = s;
        sq = x * x;
        short_hist.push_back(sq);
        if (short_hist.size() > SHORT_SIZE) void'(short_hist.pop_front());
        if (!f || !m_init) begin
            long_hist.push_back(sq);
            if (long_hist.size() > LONG_SIZE) void'(long_hist.pop_front());
            long_cnt++;
            if (long_cnt >= LONG_SIZE) m_init = 1'b1;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".energy"},    energy,    exp_energy());
        check({tag, ".TH"},        TH,        exp_th());
        check({tag, ".initDone"},  {63'd0, initDone},  {63'd0, m_init});
        check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_ov});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input logic signed [SAMPLE_W-1:0] s, input bit f,
                        input string tag);
        @(negedge clock);
        reset        = 1'b0;
        sample_valid = v;
        sample_in    = s;
        freeze       = f;
        @(posedge clock);
        model_step(v, s, f);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset        = 1'b1;
        sample_valid = 1'($urandom_range(0, 1));
        sample_in    = SAMPLE_W'($urandom);
        freeze       = 1'($urandom_range(0, 1));
        @(posedge clock);
        model_reset();
        #1;
        check({tag, ".energy0"},  energy, 64'd0);
        check({tag, ".TH0"},      TH, exp_th());
        check({tag, ".init0"},    {63'd0, initDone},  64'd0);
        check({tag, ".ov0"},      {63'd0, out_valid}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit f_state;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        freeze       = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        do_reset("init");

        // Constant 4: energy saturates at 240, TH reaches 496 on sample 31.
        for (int i = 0; i < LONG_SIZE; i++) begin
            step(1'b1, 16'sd4, 1'b0, "c4");
            if (i == 14) check("c4.e240", energy, 64'd240);
            if (i == 29) begin
                check("c4.th480",   TH, 64'd480);
                check("c4.noinit",  {63'd0, initDone}, 64'd0);
            end
        end
        check("c4.th496", TH, 64'd496);
        check("c4.init",  {63'd0, initDone}, 64'd1);
        check("c4.e240b", energy, 64'd240);

        // Frozen: energy tracks 10s, TH holds.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'sd10, 1'b1, "frz");
            if (i == 14) check("frz.e1500", energy, 64'd1500);
        end
        check("frz.th_hold", TH, 64'd496);
        for (int i = 0; i < LONG_SIZE; i++) step(1'b1, 16'sd10, 1'b0, "unfrz");
        check("unfrz.th3100", TH, 64'd3100);

        // Mid-stream reset, then a single sample of 1.
        do_reset("mid");
        for (int i = 0; i < LONG_SIZE; i++) step(1'b1, 16'sd4, 1'b0, "refill");
        check("refill.e", energy, 64'd240);
        check("refill.th", TH, 64'd496);
        do_reset("mid2");
        step(1'b1, 16'sd1, 1'b0, "one");
        check("one.e", energy, 64'd1);
`ifndef TH_FLOOR_EN
        check("one.th", TH, 64'd1);
`endif

        // Most negative sample: largest squares, no sign flip.
        do_reset("neg");
        for (int i = 0; i < LONG_SIZE; i++) step(1'b1, -16'sd32768, 1'b0, "neg");
        check("neg.e", energy, 64'd15 << 30);
        check("neg.th", TH, 64'd31 << 30);

        // Gaps: energy moves by 4 only on valid cycles.
        do_reset("gap");
        for (int i = 0; i < 8; i++) begin
            step(i % 2 == 0, 16'sd2, 1'b0, "gap");
            check("gap.e", energy, 64'(4 * ((i / 2) + 1)));
            check("gap.ov", {63'd0, out_valid}, (i % 2 == 0) ? 64'd1 : 64'd0);
        end

        // Near-silence, then 3s.
        do_reset("flr");
        for (int i = 0; i < LONG_SIZE; i++) step(1'b1, 16'sd0, 1'b0, "flr0");
`ifdef TH_FLOOR_EN
        check("flr.th64", TH, 64'd64);
`else
        check("flr.th0", TH, 64'd0);
`endif
        check("flr.init", {63'd0, initDone}, 64'd1);
        for (int i = 0; i < LONG_SIZE; i++) step(1'b1, 16'sd3, 1'b0, "flr3");
        check("flr.th279", TH, 64'd279);

        // Randomized traffic with freeze bursts and occasional reset.
        do_reset("rnd");
        f_state = 1'b0;
        for (int i = 0; i < 800; i++) begin
            logic signed [SAMPLE_W-1:0] s;
            if ($urandom_range(0, 9) == 0) f_state = ~f_state;
            case ($urandom_range(0, 7))
                0:       s = -16'sd32768;
                1:       s = 16'sd32767;
                2:       s = SAMPLE_W'($urandom_range(0, 15)) - 16'sd8;
                default: s = SAMPLE_W'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) do_reset("rnd.rst");
            else step($urandom_range(0, 3) != 0, s, f_state, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

    // Watchdog: the run is bounded, this only guards against a stuck bench.
    initial begin
        #500000;
        errors_cnt++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/energy_threshold_estimator.md
Name: energy_threshold_estimator

Overview:
- Front-end feeding the event-detection FSM. Squares incoming signed samples and keeps two moving sums: a short-window `energy` and a long-window background `TH`.
- Asserts `initDone` once the long window has filled.
- Honours `freeze` from the detector: while an event is pending or active, the background `TH` holds, so event energy never contaminates the threshold.

Parameters:
- SAMPLE_W, 16, signed sample width
- SHORT_SIZE, 15, short window length in samples (energy)
- LONG_SIZE, 31, long window length in samples (threshold); must be > SHORT_SIZE
- TH_FLOOR, 64, minimum TH value (used only with TH_FLOOR_EN)

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sample_in  input  SAMPLE_W  signed input sample
- sample_valid  input  1  sample_in valid this cycle
- freeze  input  1  from detector; holds long-window update when high
- energy  output  64  signed, short-window sum of squares
- TH  output  64  signed, long-window sum of squares
- initDone  output  1  long window filled; sticky until reset
- out_valid  output  1  one-cycle pulse: energy/TH updated this cycle

Behaviour:
- Reset state (cycle after reset=1): energy=0, TH=0, initDone=0, out_valid=0. Both circular buffers cleared to 0, write pointers=0, fill counter=0. Reset overrides every other input and applies mid-stream.
- Square: sq = sample_in*sample_in, 32-bit unsigned-in-signed; worst case -32768^2 = 2^30, no overflow. Sums are 64-bit signed and always non-negative.
- Short window (every accepted sample):
  - energy <= energy + sq - sbuf[sptr]; sbuf[sptr] <= sq.
  - sptr wraps SHORT_SIZE-1 -> 0.
  - Before the window fills, the evicted entries are 0, so energy is the sum of the samples received so far.
- Long window: same scheme with lbuf/lptr/LONG_SIZE. Updates only when sample_valid=1 AND (freeze=0 OR initDone=0).
- Freeze is ignored while initDone=0.
- While frozen: lptr, lbuf and the TH register hold; the short window keeps updating.
- On freeze release, the long window resumes from the held contents. No catch-up with samples received during the freeze.
- Fill counter counts accepted long-window samples, saturating at LONG_SIZE. initDone rises in the same cycle TH reflects the LONG_SIZE-th sample.
- Latency: sample accepted at edge N -> energy/TH/out_valid visible after edge N (1 cycle).
- out_valid = registered sample_valid. It pulses even when frozen.
- sample_valid=0: no state change; out_valid=0.
- Simultaneous freeze rising and sample_valid: freeze wins for the long window in that cycle (TH holds); the short window accepts the sample.

Optional Feature:
- Macro TH_FLOOR_EN.
- Defined: the TH output is max(long_sum, TH_FLOOR). The internal long_sum is unclamped, so the floor does not corrupt the moving sum. This prevents triggering on near-silence.
- Undefined: TH = long_sum directly; the TH_FLOOR parameter is unused.

Test Plan:
- Constant sample 4, valid every cycle, freeze=0 -> energy=240 after the 15th sample and stays 240; TH=496 and initDone=1 after the 31st sample, not before (TH=480 after the 30th).
- After init, assert freeze, then feed sample 10 for 40 cycles -> energy=1500 after 15 samples; TH stays 496. Deassert freeze and feed 31 more samples of 10 -> TH=3100.
- Sample -32768 for 31 cycles -> energy=15*2^30, TH=31*2^30 exactly; no sign flip.
- Gaps: sample_valid toggling 1,0,1,0 with sample 2 -> energy increments by 4 only on valid cycles; out_valid pulses only after valid cycles.
- Reset asserted mid-stream with energy=240, TH=496 -> next cycle all outputs 0, initDone=0. A subsequent sample 1 gives energy=1, TH=1.
- TH_FLOOR_EN defined, TH_FLOOR=64, input 0 for 31 samples -> TH=64, initDone=1. Then sample 3 x31 -> TH=279.
